// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: pops words, absorbs the
// one-cycle read latency in a 3-entry buffer, streams them with burst framing.
module fifo_stream_reader #(
   parameter int WIDTH     = 1024,
   parameter int BURST_LEN = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_fifo_empty,
   input  logic [WIDTH-1:0] i_fifo_rddata,
   output logic             o_fifo_rden,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_last,
   input  logic             i_ready,
   output logic             o_busy,
   output logic [31:0]      o_word_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] mem [3];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [1:0]       buf_cnt;
   logic             inflight;
   logic             fetch_room;
   logic             capture;
   logic             take;
   logic [15:0]      beat;

   function automatic logic [1:0] inc3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Buffered plus in-flight words must stay within the 3 buffer slots.
   assign fetch_room = ({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3;
   assign capture    = inflight;
   assign o_valid    = (buf_cnt != 2'd0);
   assign take       = o_valid && i_ready;
   assign o_data     = mem[rd_ptr];
   assign o_last     = o_valid && (beat == LAST_BEAT);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; enable is ignored while draining.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (i_enable) state_nxt = RUN;
         RUN:     if (!i_enable) state_nxt = DRAIN;
         DRAIN:   if (buf_cnt == 2'd0 && !inflight) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: pop only from registered state and the FIFO empty flag.
   always_comb begin
      o_fifo_rden = 1'b0;
      o_busy      = (state != IDLE);
      if (state == RUN && !i_fifo_empty && fetch_room) o_fifo_rden = 1'b1;
   end

   // Prefetch buffer: capture the word popped last cycle, retire the head.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         buf_cnt  <= 2'd0;
         inflight <= 1'b0;
         for (int i = 0; i < 3; i++) mem[i] <= '0;
      end else begin
         inflight <= o_fifo_rden;
         if (capture) begin
            mem[wr_ptr] <= i_fifo_rddata;
            wr_ptr      <= inc3(wr_ptr);
         end
         if (take) rd_ptr <= inc3(rd_ptr);
         buf_cnt <= buf_cnt + {1'b0, capture} - {1'b0, take};
      end
   end

   // Burst beat index and total accepted-beat counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat       <= 16'd0;
         o_word_cnt <= 32'd0;
      end else if (take) begin
         beat       <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
         o_word_cnt <= o_word_cnt + 32'd1;
      end
   end

endmodule
